// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//   Memory-mapped controller for the 64-bit tick counter. It generates the
//   counter increment strobe through a programmable prescaler, compares the
//   counter against a 64-bit compare value and raises a pending interrupt on
//   match. In periodic mode it reloads the counter to zero by taking over the
//   counter's single write port for two cycles (low word, then high word).
//
//   Register map (relative to BASE_ADDR):
//     +0x0  CTRL    [0] EN, [1] MODE (1 = periodic), [2] IE, [15:8] PSC
//     +0x4  CMP_LO  compare value bits [31:0]
//     +0x8  CMP_HI  compare value bits [63:32]
//     +0xC  STATUS  [0] PEND, write 1 to clear
//     +0x10 SNAP    counter high word latched on a read of CNT_LO_ADDR
//                   (only with TIMER_CTRL_SNAPSHOT_EN defined, otherwise 0)
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     addr/wr_en/wdata    CPU store/load path
//     rdata               combinational read data for controller registers
//     cpu_ready           low while the reload sequence owns the counter port
//     cnt                 current counter value
//     cnt_en              counter increment strobe
//     ctr_addr/ctr_wr_en/ctr_wdata  counter write port (CPU path or reload)
//     irq                 STATUS.PEND & CTRL.IE
//
//   Optional feature macro: TIMER_CTRL_SNAPSHOT_EN
// -----------------------------------------------------------------------------
module timer_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0010,
    parameter logic [31:0] CNT_LO_ADDR = 32'h2000_0004,
    parameter logic [31:0] CNT_HI_ADDR = 32'h2000_0008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        cpu_ready,
    input  logic [63:0] cnt,
    output logic        cnt_en,
    output logic [31:0] ctr_addr,
    output logic        ctr_wr_en,
    output logic [31:0] ctr_wdata,
    output logic        irq
);

    localparam logic [31:0] A_CTRL = BASE_ADDR;
    localparam logic [31:0] A_CMPL = BASE_ADDR + 32'h4;
    localparam logic [31:0] A_CMPH = BASE_ADDR + 32'h8;
    localparam logic [31:0] A_STAT = BASE_ADDR + 32'hC;
    localparam logic [31:0] A_SNAP = BASE_ADDR + 32'h10;

    typedef enum logic [1:0] {IDLE, RUN, RLD_LO, RLD_HI} state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d, mode_q, mode_d, ie_q, ie_d;
    logic [7:0]  psc_q, psc_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [63:0] cmp_q, cmp_d;
    logic        pend_q, pend_d;
    logic [31:0] snap_rd;

    // Reset overrides the reload state combinationally so the port mux
    // returns to the CPU path in the same cycle reset is asserted.
    logic in_rld, running, cpu_we;
    logic wr_ctrl, wr_cmpl, wr_cmph, wr_stat;
    logic match, tick;

    assign in_rld  = !rst && (state_q == RLD_LO || state_q == RLD_HI);
    assign running = !rst && (state_q == RUN);
    assign cpu_we  = wr_en && !in_rld;
    assign wr_ctrl = cpu_we && (addr == A_CTRL);
    assign wr_cmpl = cpu_we && (addr == A_CMPL);
    assign wr_cmph = cpu_we && (addr == A_CMPH);
    assign wr_stat = cpu_we && (addr == A_STAT);
    assign match   = running && (cnt >= cmp_q);
    assign tick    = running && (pcnt_q == psc_q);
    assign irq     = pend_q & ie_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (wr_ctrl && wdata[0]) state_d = RUN;
            RUN: begin
                if (match) begin
                    // A concurrent EN=0 write cancels the reload.
                    if ((wr_ctrl && !wdata[0]) || !mode_q) state_d = IDLE;
                    else                                   state_d = RLD_LO;
                end else if (wr_ctrl && !wdata[0]) begin
                    state_d = IDLE;
                end
            end
            RLD_LO: state_d = RLD_HI;
            RLD_HI: state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cnt_en    = tick;
        cpu_ready = !in_rld;
        ctr_addr  = addr;
        ctr_wr_en = wr_en;
        ctr_wdata = wdata;
        if (in_rld) begin
            ctr_addr  = (state_q == RLD_LO) ? CNT_LO_ADDR : CNT_HI_ADDR;
            ctr_wr_en = 1'b1;
            ctr_wdata = 32'h0;
        end
    end

    // ---------------- register file next state ----------------
    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        ie_d   = ie_q;
        psc_d  = psc_q;
        cmp_d  = cmp_q;
        pend_d = pend_q;
        if (wr_ctrl) begin
            en_d   = wdata[0];
            mode_d = wdata[1];
            ie_d   = wdata[2];
            psc_d  = wdata[15:8];
        end
        if (match && !mode_q) en_d = 1'b0;
        if (wr_cmpl) cmp_d[31:0]  = wdata;
        if (wr_cmph) cmp_d[63:32] = wdata;
        // Set has priority over a same-cycle write-1-to-clear.
        if (match)                    pend_d = 1'b1;
        else if (wr_stat && wdata[0]) pend_d = 1'b0;
        // Prescale count only advances in RUN; it restarts after a reload
        // and on every CTRL write.
        if (wr_ctrl || state_q != RUN) pcnt_d = 8'd0;
        else if (tick)                 pcnt_d = 8'd0;
        else                           pcnt_d = pcnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 1'b0;
            mode_q <= 1'b0;
            ie_q   <= 1'b0;
            psc_q  <= 8'd0;
            cmp_q  <= '1;
            pend_q <= 1'b0;
            pcnt_q <= 8'd0;
        end else begin
            en_q   <= en_d;
            mode_q <= mode_d;
            ie_q   <= ie_d;
            psc_q  <= psc_d;
            cmp_q  <= cmp_d;
            pend_q <= pend_d;
            pcnt_q <= pcnt_d;
        end
    end

`ifdef TIMER_CTRL_SNAPSHOT_EN
    // Reading the low word freezes the high word so software sees a
    // coherent 64-bit value.
    logic [31:0] snap_q;
    always_ff @(posedge clk) begin
        if (rst)                                 snap_q <= 32'h0;
        else if (!wr_en && addr == CNT_LO_ADDR)  snap_q <= cnt[63:32];
    end
    assign snap_rd = snap_q;
`else
    assign snap_rd = 32'h0;
`endif

    // ---------------- read mux ----------------
    always_comb begin
        rdata = 32'h0;
        case (addr)
            A_CTRL: rdata = {16'h0, psc_q, 5'h0, ie_q, mode_q, en_q};
            A_CMPL: rdata = cmp_q[31:0];
            A_CMPH: rdata = cmp_q[63:32];
            A_STAT: rdata = {31'h0, pend_q};
            A_SNAP: rdata = snap_rd;
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Memory-mapped controller that sequences the 64-bit tick counter (TDR0/TDR1 at 0x2000_0004/0x2000_0008).
- Generates the counter's `cnt_en` through a programmable prescaler and compares the counter value against a 64-bit compare register.
- Raises an interrupt on match. In periodic mode it reloads the counter to zero.
- Arbitrates the counter's single write port between the CPU store path and its own reload sequencer.

Parameters:
- BASE_ADDR, 32'h2000_0010, base of the controller registers: CTRL +0x0, CMP_LO +0x4, CMP_HI +0x8, STATUS +0xC.
- CNT_LO_ADDR, 32'h2000_0004, counter low-word address driven during reload.
- CNT_HI_ADDR, 32'h2000_0008, counter high-word address driven during reload.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous to clk, active-high
- addr  in  32  CPU store/load address
- wr_en  in  1  CPU store strobe
- wdata  in  32  CPU store data
- rdata  out  32  combinational read data for controller registers; 0 for other addresses
- cpu_ready  out  1  0 while the reload sequence owns the counter port; CPU holds the store
- cnt  in  64  current counter value
- cnt_en  out  1  counter increment strobe
- ctr_addr  out  32  counter port address
- ctr_wr_en  out  1  counter port write strobe
- ctr_wdata  out  32  counter port write data
- irq  out  1  interrupt, equals STATUS.PEND & CTRL.IE

Behaviour:
- Registers:
  - CTRL: [0] EN, [1] MODE (0 one-shot, 1 periodic), [2] IE, [15:8] PSC, others read 0.
  - CMP_LO / CMP_HI: 32 bits each, read/write.
  - STATUS: [0] PEND, write-1-to-clear.
- Reset: CTRL=0, CMP=64'hFFFF_FFFF_FFFF_FFFF, PEND=0, prescale count=0, state=IDLE. All outputs 0 except `cpu_ready`=1 and `ctr_addr`=addr.
- FSM states: IDLE, RUN, RLD_LO, RLD_HI.
  - IDLE -> RUN when EN=1 is written.
  - RUN -> IDLE when EN=0 is written.
- Prescaler: in RUN, `cnt_en`=1 on the cycle the prescale count equals PSC; the count then wraps to 0, otherwise it increments.
  - PSC=0 gives `cnt_en` every cycle.
  - Any CTRL write clears the prescale count.
  - `cnt_en`=0 outside RUN.
- Match: in RUN, match = (cnt >= CMP), 64-bit unsigned, evaluated every cycle. On match, PEND<=1 next cycle.
  - One-shot: EN<=0, next state IDLE.
  - Periodic: next state RLD_LO.
  - Match is not re-evaluated in IDLE, RLD_LO or RLD_HI.
- RLD_LO (1 cycle): `ctr_wr_en`=1, `ctr_addr`=CNT_LO_ADDR, `ctr_wdata`=0, `cnt_en`=0, `cpu_ready`=0. Next state RLD_HI.
- RLD_HI (1 cycle): same, with `ctr_addr`=CNT_HI_ADDR. Next state RUN, with the prescale count cleared.
- Port mux outside RLD states: `ctr_addr`=addr, `ctr_wr_en`=wr_en, `ctr_wdata`=wdata, `cpu_ready`=1.
  - CPU stores during RLD states are not forwarded; the CPU retries once `cpu_ready`=1.
  - Controller registers are also not written while `cpu_ready`=0.
- Simultaneous events:
  - CPU W1C of PEND in the same cycle as a new match: set wins, PEND=1.
  - CPU write of EN=0 in the same cycle as a match: PEND sets, next state is IDLE, no reload.
  - CMP write in RUN takes effect on the following cycle's compare.
- Reset asserted mid-reload: FSM returns to IDLE immediately and the port mux reverts to the CPU path. The counter may hold a partial reload (low word 0); this is acceptable.
- Writing EN=1 while already running: no state change, prescale count cleared.

Optional Feature:
- Macro: TIMER_CTRL_SNAPSHOT_EN.
- Defined: a CPU read of CNT_LO_ADDR (addr match with wr_en=0, sampled every cycle) latches cnt[63:32] into a SNAP register, reset value 0. SNAP is readable at BASE_ADDR+0x10, giving a coherent 64-bit read.
- Undefined: no SNAP register; BASE_ADDR+0x10 reads 0.

Test Plan:
- Reset, then read all registers -> CTRL=0, CMP_LO=CMP_HI=FFFF_FFFF, STATUS=0; `irq`=0, `cnt_en`=0, `cpu_ready`=1.
- CTRL=0x0000_0301 (PSC=3, EN) -> `cnt_en` high every 4th cycle; first pulse on the 4th cycle after the write.
- One-shot: CMP=10, PSC=0, IE=1, EN=1 -> `irq`=1 the cycle after cnt reaches 10; EN reads 0; `cnt_en` stops.
- Periodic: CMP=5, PSC=0, MODE=1 -> after cnt=5, two consecutive writes of 0 (to 0x2000_0004 then 0x2000_0008) with `cpu_ready`=0. Counter restarts from 0; PEND stays 1 until a W1C write to STATUS (0x2000_001C with data 1).
- CPU store to 0x2000_0004 held during RLD_LO -> not forwarded; completes after `cpu_ready` returns to 1.
- W1C to STATUS in the same cycle as a new match -> PEND remains 1, `irq` stays high.
